// File: rtl/uart_tx_ovs.sv
// UART transmitter with per-bit Prescale timing on the oversampled receiver clock.
// Define UART_TX_OVS_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_ovs #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [5:0]            r_cycle;
    logic [5:0]            w_cycleNext;
    logic [BIT_W-1:0]      r_bit;
    logic [BIT_W-1:0]      w_bitNext;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_parEn;
    logic                  r_parBit;
    logic [5:0]            r_prescale;
    logic                  r_txOut;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_lastCycle;
    logic                  w_txNext;
    logic                  w_busyNext;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cycle <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cycle <= w_cycleNext;
            r_bit   <= w_bitNext;
        end
    end

    assign w_lastCycle = (r_cycle == (r_prescale - 6'd1));

    always_comb begin
        w_stateNext = r_state;
        w_cycleNext = r_cycle;
        w_bitNext   = r_bit;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (DATA_VALID) begin
                    w_stateNext = START;
                    w_cycleNext = '0;
                    w_bitNext   = '0;
                    w_accept    = 1'b1;
                end
            end
            START: begin
                if (w_lastCycle) begin
                    w_stateNext = DATA;
                    w_cycleNext = '0;
                    w_bitNext   = '0;
                end else begin
                    w_cycleNext = r_cycle + 6'd1;
                end
            end
            DATA: begin
                if (w_lastCycle) begin
                    w_cycleNext = '0;
                    if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                        w_stateNext = r_parEn ? PARITY : STOP;
                        w_bitNext   = '0;
                    end else begin
                        w_bitNext = r_bit + 1'b1;
                    end
                end else begin
                    w_cycleNext = r_cycle + 6'd1;
                end
            end
            PARITY: begin
                if (w_lastCycle) begin
                    w_stateNext = STOP;
                    w_cycleNext = '0;
                    w_bitNext   = '0;
                end else begin
                    w_cycleNext = r_cycle + 6'd1;
                end
            end
            STOP: begin
                if (w_lastCycle) begin
                    w_cycleNext = '0;
`ifdef UART_TX_OVS_TWO_STOP_EN
                    // r_bit counts the stop bits here
                    if (r_bit == BIT_W'(1)) begin
                        w_stateNext = IDLE;
                        w_bitNext   = '0;
                    end else begin
                        w_bitNext = r_bit + 1'b1;
                    end
`else
                    w_stateNext = IDLE;
                    w_bitNext   = '0;
`endif
                end else begin
                    w_cycleNext = r_cycle + 6'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cycleNext = '0;
                w_bitNext   = '0;
            end
        endcase
    end

    // Line value is decided from the upcoming state so TX_OUT can be a plain register.
    always_comb begin
        w_txNext   = 1'b1;
        w_busyNext = (w_stateNext != IDLE);
        case (w_stateNext)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = r_data[w_bitNext];
            PARITY:  w_txNext = r_parBit;
            default: w_txNext = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data     <= '0;
            r_parEn    <= 1'b0;
            r_parBit   <= 1'b0;
            r_prescale <= '0;
            r_txOut    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data     <= P_DATA;
                r_parEn    <= PAR_EN;
                r_parBit   <= (^P_DATA) ^ PAR_TYP;
                r_prescale <= (Prescale == 6'd0) ? 6'd1 : Prescale;
            end
            r_txOut <= w_txNext;
            r_busy  <= w_busyNext;
        end
    end

    assign TX_OUT = r_txOut;
    assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ovs.sv
// Directed self-checking bench for uart_tx_ovs: checks TX_OUT and Busy every cycle
// of each frame against hand-built expected frames.
module tb_uart_tx_ovs;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int checkCount = 0;
    int failCount  = 0;

`ifdef UART_TX_OVS_TWO_STOP_EN
    localparam int EXTRA_STOP = 1;
`else
    localparam int EXTRA_STOP = 0;
`endif

    uart_tx_ovs #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic observed, input logic expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the request is taken at the next posedge and the task
    // returns at the following negedge, i.e. in cycle 0 of the frame.
    task automatic applyStimulus(input logic [7:0] data, input logic parEn,
                                 input logic parTyp, input logic [5:0] presc);
        P_DATA     = data;
        PAR_EN     = parEn;
        PAR_TYP    = parTyp;
        Prescale   = presc;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    // frame bit 0 is the start bit; bits past nBits are stop-level ones.
    // injectAt >= 0 raises a competing request and changes config mid-frame.
    // stopAt >= 0 ends early after that many cycles without the idle check.
    task automatic checkOutput(input string name, input logic [11:0] frame, input int nBits,
                               input int presc, input int injectAt, input int stopAt);
        int totalCycles;
        logic expBit;
        totalCycles = (nBits + EXTRA_STOP) * presc;
        for (int k = 0; k < totalCycles; k++) begin
            if (stopAt >= 0 && k == stopAt) return;
            if (k == injectAt) begin
                P_DATA     = 8'h00;
                PAR_EN     = 1'b1;
                Prescale   = 6'd2;
                DATA_VALID = 1'b1;
            end
            if (k == injectAt + 1) DATA_VALID = 1'b0;
            expBit = ((k / presc) < nBits) ? frame[k / presc] : 1'b1;
            check($sformatf("%s tx c%0d", name, k), TX_OUT, expBit);
            check($sformatf("%s busy c%0d", name, k), Busy, 1'b1);
            @(negedge CLK);
        end
        check($sformatf("%s busy end", name), Busy, 1'b0);
        check($sformatf("%s tx end", name), TX_OUT, 1'b1);
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        #2;
        check("reset tx", TX_OUT, 1'b1);
        check("reset busy", Busy, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("idle tx", TX_OUT, 1'b1);
        check("idle busy", Busy, 1'b0);

        // 0xA5 has four ones: even parity 0, odd parity 1
        applyStimulus(8'hA5, 1'b1, 1'b0, 6'd8);
        checkOutput("s1", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8, -1, -1);
        @(negedge CLK);
        applyStimulus(8'hA5, 1'b1, 1'b1, 6'd8);
        checkOutput("s2", {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 8, -1, -1);

        @(negedge CLK);
        applyStimulus(8'hFF, 1'b0, 1'b0, 6'd16);
        checkOutput("s3", {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 16, -1, -1);

        @(negedge CLK);
        applyStimulus(8'h3C, 1'b0, 1'b0, 6'd8);
        checkOutput("s4", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 8, 20, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("s4 stays idle %0d", i), Busy, 1'b0);
        end

        applyStimulus(8'h00, 1'b0, 1'b0, 6'd8);
        checkOutput("s5", {2'b00, 1'b1, 8'h00, 1'b0}, 10, 8, -1, 30);
        check("s5 pre-reset tx", TX_OUT, 1'b0);
        check("s5 pre-reset busy", Busy, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check("s5 async tx", TX_OUT, 1'b1);
        check("s5 async busy", Busy, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("s5 post-reset busy", Busy, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, 6'd8);
        checkOutput("s5b", {2'b00, 1'b1, 8'h55, 1'b0}, 10, 8, -1, -1);

        // Back-to-back, odd parity: 0x00, 0xFF, 0x81 all have even popcount -> parity 1
        @(negedge CLK);
        applyStimulus(8'h00, 1'b1, 1'b1, 6'd8);
        checkOutput("s6a", {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 8, -1, -1);
        applyStimulus(8'hFF, 1'b1, 1'b1, 6'd8);
        checkOutput("s6b", {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 8, -1, -1);
        applyStimulus(8'h81, 1'b1, 1'b1, 6'd8);
        checkOutput("s6c", {1'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11, 8, -1, -1);

        applyStimulus(8'h6B, 1'b0, 1'b0, 6'd1);
        checkOutput("s6p1", {2'b00, 1'b1, 8'h6B, 1'b0}, 10, 1, -1, -1);
        applyStimulus(8'h2D, 1'b0, 1'b0, 6'd0);
        checkOutput("s6p0", {2'b00, 1'b1, 8'h2D, 1'b0}, 10, 1, -1, -1);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
